clkgen_div: RTL
===============

Name: clkgen_div

Overview:
Parametrised successor to the fixed divide-by-4 board clock generator. Divides board clock CLK by a runtime-selectable integer ratio and produces a registered divided clock plus a one-cycle clock-enable strobe. Ratio changes take effect only at period boundaries, so the output never produces runt pulses. Also generates a synchronised, stretched active-high power_on_reset for the system core. Sits in each board top-level between the board pins and the system instance.

Parameters:
DIV_W, 8, width of ratio registers and counter.
DEFAULT_DIV, 4, ratio after reset; clamped to the range 2..2^DIV_W-1.
RESET_CYCLES, 16, CLK cycles power_on_reset is held after the synchronised reset release; minimum 1.

Ports:
CLK  input  1  board clock; all logic on posedge.
RST_N  input  1  asynchronous active-low reset.
div  input  DIV_W  requested divide ratio; values 0 and 1 clamp to 2.
div_load  input  1  sample div into the pending-ratio register this cycle.
clk  output  1  divided clock, registered.
clk_en  output  1  one-CLK-cycle pulse in the first CLK cycle of each clk high phase.
div_busy  output  1  pending ratio not yet applied.
power_on_reset  output  1  active-high synchronised system reset.

Behaviour:
- Reset (RST_N low, asynchronous, takes effect without a CLK edge): cnt=0, clk=0, clk_en=0, cur_div=clamp(DEFAULT_DIV), pend_div=cur_div, div_busy=0, power_on_reset=1, synchroniser=0, stretch counter=0.
- Release: RST_N passes through a 2-flop synchroniser. When the synchronised signal is 1, the stretch counter counts CLK cycles. power_on_reset falls on the edge on which the count reaches RESET_CYCLES, and then stays 0. First CLK edge after release = edge 1; power_on_reset is 0 from edge 2+RESET_CYCLES.
- Divider runs only while the synchronised reset is 1. It is held at its reset state otherwise.
- Counter: cnt counts 0..cur_div-1 and wraps to 0.
- Let H = cur_div - (cur_div>>1), i.e. ceil(N/2). clk=1 while cnt<H, else 0. Period = cur_div CLK cycles: high H cycles, low floor(N/2) cycles.
- clk_en=1 exactly in the cycles with cnt==0. First pulse occurs on the first divider cycle after release.
- Outputs are all registered; clk and clk_en change on the same CLK edge.
- Ratio change:
  - div_load=1 latches clamp(div) into pend_div and sets div_busy=1 on the next edge.
  - At a boundary (cnt==cur_div-1 while div_busy=1): cur_div<=pend_div, cnt<=0, div_busy<=0.
  - Load while busy: overwrites pend_div; the last load wins.
  - Load in a boundary cycle: the boundary applies the old pend_div (or none), and the new value waits for the next boundary with div_busy=1.
  - Loading a value equal to cur_div still sets busy for one period.
- Width rules: cnt and cur_div are DIV_W bits. Max ratio 2^DIV_W-1, so there is no counter overflow.
- Reset mid-operation: immediate return to reset state; pending load discarded.

Optional Feature:
Macro CLKGEN_DIV_RUNTIME_EN.
- Defined: div/div_load function as above.
- Undefined: ports remain; div and div_load are ignored; cur_div is fixed at clamp(DEFAULT_DIV); div_busy is tied 0. No pend_div register is synthesised.

Test Plan:
1. Defaults, RST_N released after 3 cycles -> power_on_reset=1 through edge 17, 0 from edge 18. clk: 2 high/2 low, period 4. clk_en pulses every 4 cycles, aligned with clk rising.
2. (macro defined) div=5, div_load at cnt=1 -> div_busy=1 until boundary at cnt=3. Next period is 3 high/2 low and clk_en period is 5. div_busy=0 from the boundary.
3. (macro defined) div=0, then div=1 -> ratio 2: clk toggles every CLK cycle and clk_en is high while clk high. div=255 with DIV_W=8 -> 128 high/127 low.
4. (macro defined) load 3 then 7 within one period, and a load of 9 in a boundary cycle -> 7 applied first; 9 applied one period later, busy throughout.
5. RST_N pulled low mid-high-phase, asynchronous to CLK -> clk=0, clk_en=0, div_busy=0, power_on_reset=1 immediately. After release, the sequence of test 1 repeats.
6. Macro undefined, div=6 and div_load pulsed -> period stays 4, div_busy stays 0.

Source files
------------

// File: rtl/clkgen_div.sv
// Board clock divider: runtime-selectable integer ratio, runt-free ratio changes, clk_en strobe
// and a synchronised, stretched power_on_reset. Define CLKGEN_DIV_RUNTIME_EN to enable div/div_load.
module clkgen_div #(
  parameter int unsigned DIV_W        = 8,
  parameter int unsigned DEFAULT_DIV  = 4,
  parameter int unsigned RESET_CYCLES = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [DIV_W-1:0] div,
  input  logic             div_load,
  output logic             clk,
  output logic             clk_en,
  output logic             div_busy,
  output logic             power_on_reset
);

  localparam longint unsigned MaxDiv = (64'd1 << DIV_W) - 64'd1;
  localparam longint unsigned DefDivClamped =
      (DEFAULT_DIV < 2) ? 64'd2 :
      ((64'(DEFAULT_DIV) > MaxDiv) ? MaxDiv : 64'(DEFAULT_DIV));
  localparam logic [DIV_W-1:0] DefDiv = DIV_W'(DefDivClamped);
  localparam int unsigned RstCycles = (RESET_CYCLES < 1) ? 1 : RESET_CYCLES;
  localparam int unsigned StW = $clog2(RstCycles + 1);

  // ---------------------------------------------------------------------------------------------
  // Reset synchroniser and power_on_reset stretcher
  // ---------------------------------------------------------------------------------------------
  logic [1:0]     sync_q;
  logic           rst_sync;
  logic [StW-1:0] stretch_q, stretch_d;
  logic           por_q, por_d;

  assign rst_sync = sync_q[1];

  always_comb begin
    stretch_d = stretch_q;
    por_d     = por_q;
    if (rst_sync && por_q) begin
      stretch_d = stretch_q + StW'(1);
      if (stretch_d == StW'(RstCycles)) begin
        por_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q    <= 2'b00;
      stretch_q <= '0;
      por_q     <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], 1'b1};
      stretch_q <= stretch_d;
      por_q     <= por_d;
    end
  end

  assign power_on_reset = por_q;

  // ---------------------------------------------------------------------------------------------
  // Ratio selection
  // ---------------------------------------------------------------------------------------------
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic             run_q, run_d;
  logic             wrap;

  // run_q marks that cnt_q is live; the first running edge starts a fresh period at cnt 0.
  assign wrap = run_q && (cnt_q == cur_div_q - DIV_W'(1));

`ifdef CLKGEN_DIV_RUNTIME_EN
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             busy_q, busy_d;

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
    return (v < DIV_W'(2)) ? DIV_W'(2) : v;
  endfunction

  always_comb begin
    cur_div_d  = DefDiv;
    pend_div_d = DefDiv;
    busy_d     = 1'b0;
    if (rst_sync) begin
      cur_div_d  = cur_div_q;
      pend_div_d = pend_div_q;
      busy_d     = busy_q;
      if (wrap && busy_q) begin
        cur_div_d = pend_div_q;
        busy_d    = 1'b0;
      end
      // A load in the boundary cycle lands after the swap, so it waits for the next boundary.
      if (div_load) begin
        pend_div_d = clamp_div(div);
        busy_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cur_div_q  <= DefDiv;
      pend_div_q <= DefDiv;
      busy_q     <= 1'b0;
    end else begin
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      busy_q     <= busy_d;
    end
  end

  assign div_busy = busy_q;
`else
  logic unused_runtime;

  assign cur_div_q      = DefDiv;
  assign cur_div_d      = DefDiv;
  assign div_busy       = 1'b0;
  assign unused_runtime = ^{div, div_load};
`endif

  // ---------------------------------------------------------------------------------------------
  // Divider counter and registered outputs
  // ---------------------------------------------------------------------------------------------
  logic clk_q, clk_d;
  logic clk_en_q, clk_en_d;

  always_comb begin
    run_d    = 1'b0;
    cnt_d    = '0;
    clk_d    = 1'b0;
    clk_en_d = 1'b0;
    if (rst_sync) begin
      run_d = 1'b1;
      if (run_q && !wrap) begin
        cnt_d = cnt_q + DIV_W'(1);
      end
      // Outputs are decoded from the next count so they line up with the registered cnt.
      clk_d    = cnt_d < (cur_div_d - (cur_div_d >> 1));
      clk_en_d = (cnt_d == '0);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      clk_q    <= 1'b0;
      clk_en_q <= 1'b0;
    end else begin
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      clk_q    <= clk_d;
      clk_en_q <= clk_en_d;
    end
  end

  assign clk    = clk_q;
  assign clk_en = clk_en_q;

endmodule
